// File: rtl/efpga_seq_pkg.sv
// Shared types for the eFPGA power-up sequencer: state encoding, vector widths
// and bit positions inside the interface-enable vector.
package efpga_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_UNGATE    = 3'd1,
    ST_RST_REL   = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_RUN       = 3'd4,
    ST_SHUTDOWN  = 3'd5,
    ST_ERROR     = 3'd6
  } seq_state_e;

  localparam int CNT_W = 16;
  localparam int RST_W = 4;
  localparam int EN_W  = 7;

  localparam int EN_TCDM0  = 0;
  localparam int EN_TCDM1  = 1;
  localparam int EN_TCDM2  = 2;
  localparam int EN_TCDM3  = 3;
  localparam int EN_APB    = 4;
  localparam int EN_EVENTS = 5;
  localparam int EN_UDMA   = 6;

  localparam logic [RST_W-1:0] RST_ALL = '1;

endpackage

// File: rtl/efpga_seq_ctrl_timer.sv
// Saturating 16-bit interval timer. 'load' marks the first cycle of a new
// interval; expire is high in the last cycle of a 'limit'-cycle interval.
module seq_timer
  import efpga_seq_pkg::*;
(
  input  logic             HCLK,
  input  logic             HRESET,
  input  logic             load,
  input  logic [CNT_W-1:0] limit,
  output logic             expire
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] elapsed;

  // load arrives one edge after the state change, so its cycle counts as the first
  always_ff @(posedge HCLK) begin
    if (HRESET)           cnt <= '0;
    else if (load)        cnt <= CNT_W'(1);
    else if (cnt != '1)   cnt <= cnt + CNT_W'(1);
  end

  assign elapsed = load ? '0 : cnt;
  assign expire  = ({1'b0, elapsed} + (CNT_W+1)'(1)) >= {1'b0, limit};

endmodule

// File: rtl/efpga_seq_ctrl.sv
// eFPGA power sequencer: ungate FIFO clock, release resets LSB first, wait for
// configuration, enable interfaces; orderly shutdown and error recovery.
module efpga_seq_ctrl
  import efpga_seq_pkg::*;
#(
  parameter int               STEP_CYCLES    = 16,
  parameter int               TIMEOUT_CYCLES = 1024,
  parameter logic [EN_W-1:0]  ENABLE_MASK    = 7'h7F
)(
  input  logic             HCLK,
  input  logic             HRESET,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic             cfg_done_i,
  output logic             clk_gating_dc_fifo_o,
  output logic [RST_W-1:0] reset_type1_efpga_o,
  output logic [EN_W-1:0]  enable_efpga_o,
  output logic             busy_o,
  output logic             seq_done_o,
  output logic             error_o,
  output logic [2:0]       state_o
);

  localparam logic [CNT_W-1:0] STEP_L = CNT_W'(STEP_CYCLES);
  localparam logic [CNT_W-1:0] TMO_L  = CNT_W'(TIMEOUT_CYCLES);

  seq_state_e       state;
  logic [1:0]       step_idx;
  logic             shut_ph;
  logic             tmr_load;
  logic             tmr_exp;
  logic [CNT_W-1:0] tmr_limit;
  logic             go;

  assign tmr_limit = (state == ST_WAIT_DONE) ? TMO_L : STEP_L;
  assign state_o   = state;
  // stop beats start everywhere; in IDLE/ERROR that leaves nothing to do
  assign go        = start_i && !stop_i;

  seq_timer u_timer (
    .HCLK   (HCLK),
    .HRESET (HRESET),
    .load   (tmr_load),
    .limit  (tmr_limit),
    .expire (tmr_exp)
  );

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state                <= ST_IDLE;
      clk_gating_dc_fifo_o <= 1'b0;
      reset_type1_efpga_o  <= RST_ALL;
      enable_efpga_o       <= '0;
      busy_o               <= 1'b0;
      seq_done_o           <= 1'b0;
      error_o              <= 1'b0;
      step_idx             <= '0;
      shut_ph              <= 1'b0;
      tmr_load             <= 1'b0;
    end else begin
      seq_done_o <= 1'b0;
      tmr_load   <= 1'b0;
      unique case (state)
        ST_IDLE, ST_ERROR: begin
          if (go) begin
            state                <= ST_UNGATE;
            clk_gating_dc_fifo_o <= 1'b1;
            busy_o               <= 1'b1;
            error_o              <= 1'b0;
            tmr_load             <= 1'b1;
          end
        end

        ST_UNGATE, ST_RST_REL, ST_WAIT_DONE, ST_RUN: begin
          if (stop_i) begin
            state          <= ST_SHUTDOWN;
            enable_efpga_o <= '0;
            busy_o         <= 1'b1;
            shut_ph        <= 1'b0;
            tmr_load       <= 1'b1;
          end else if (state == ST_UNGATE) begin
            if (tmr_exp) begin
              state                  <= ST_RST_REL;
              reset_type1_efpga_o[0] <= 1'b0;
              step_idx               <= 2'd1;
              tmr_load               <= 1'b1;
            end
          end else if (state == ST_RST_REL) begin
            if (tmr_exp) begin
              reset_type1_efpga_o[step_idx] <= 1'b0;
              step_idx                      <= step_idx + 2'd1;
              tmr_load                      <= 1'b1;
              if (step_idx == 2'd3) state <= ST_WAIT_DONE;
            end
          end else if (state == ST_WAIT_DONE) begin
            if (cfg_done_i) begin
              state          <= ST_RUN;
              enable_efpga_o <= ENABLE_MASK;
              seq_done_o     <= 1'b1;
              busy_o         <= 1'b0;
              tmr_load       <= 1'b1;
            end else if (tmr_exp) begin
              state                <= ST_ERROR;
              enable_efpga_o       <= '0;
              reset_type1_efpga_o  <= RST_ALL;
              clk_gating_dc_fifo_o <= 1'b0;
              busy_o               <= 1'b0;
              error_o              <= 1'b1;
              tmr_load             <= 1'b1;
            end
          end else if (!cfg_done_i) begin
            // RUN: fabric lost its configuration
            state                <= ST_ERROR;
            enable_efpga_o       <= '0;
            reset_type1_efpga_o  <= RST_ALL;
            clk_gating_dc_fifo_o <= 1'b0;
            busy_o               <= 1'b0;
            error_o              <= 1'b1;
            tmr_load             <= 1'b1;
          end
        end

        ST_SHUTDOWN: begin
          if (tmr_exp) begin
            tmr_load <= 1'b1;
            if (!shut_ph) begin
              reset_type1_efpga_o <= RST_ALL;
              shut_ph             <= 1'b1;
            end else begin
              state                <= ST_IDLE;
              clk_gating_dc_fifo_o <= 1'b0;
              busy_o               <= 1'b0;
              shut_ph              <= 1'b0;
            end
          end
        end

        default: begin
          state                <= ST_IDLE;
          clk_gating_dc_fifo_o <= 1'b0;
          reset_type1_efpga_o  <= RST_ALL;
          enable_efpga_o       <= '0;
          busy_o               <= 1'b0;
          error_o              <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_efpga_seq_ctrl.sv
module tb_efpga_seq_ctrl;
  import efpga_seq_pkg::*;

  localparam int STEP = 4;
  localparam int TMO  = 32;

  logic       HCLK = 1'b0;
  logic       HRESET = 1'b1;
  logic       start_i = 1'b0;
  logic       stop_i = 1'b0;
  logic       cfg_done_i = 1'b0;
  logic       clk_gating_dc_fifo_o;
  logic [3:0] reset_type1_efpga_o;
  logic [6:0] enable_efpga_o;
  logic       busy_o, seq_done_o, error_o;
  logic [2:0] state_o;

  typedef struct {
    int          cyc;
    string       nm;
    logic [17:0] v;
  } exp_t;

  exp_t        q[$];
  exp_t        me;
  logic [17:0] act;
  int          n = 0;
  int          pass = 0;
  int          total = 0;

  efpga_seq_ctrl #(.STEP_CYCLES(STEP), .TIMEOUT_CYCLES(TMO), .ENABLE_MASK(7'h7F)) dut (
    .HCLK                 (HCLK),
    .HRESET               (HRESET),
    .start_i              (start_i),
    .stop_i               (stop_i),
    .cfg_done_i           (cfg_done_i),
    .clk_gating_dc_fifo_o (clk_gating_dc_fifo_o),
    .reset_type1_efpga_o  (reset_type1_efpga_o),
    .enable_efpga_o       (enable_efpga_o),
    .busy_o               (busy_o),
    .seq_done_o           (seq_done_o),
    .error_o              (error_o),
    .state_o              (state_o)
  );

  always #5 HCLK = ~HCLK;

  task automatic ex(input int c, input string nm, input logic [2:0] st, input logic ck,
                    input logic [3:0] rs, input logic [6:0] en, input logic b,
                    input logic d, input logic e);
    exp_t x;
    x.cyc = c;
    x.nm  = nm;
    x.v   = {st, ck, rs, en, b, d, e};
    q.push_back(x);
  endtask

  always @(posedge HCLK) begin
    #1;
    n = n + 1;
    total = total + 2;
    if (error_o === (state_o == 3'd6)) pass = pass + 1;
    else $display("FAIL inv_error cyc=%0d: st=%0d error_o=%b", n, state_o, error_o);
    if (busy_o === !(state_o == 3'd0 || state_o == 3'd4 || state_o == 3'd6)) pass = pass + 1;
    else $display("FAIL inv_busy cyc=%0d: st=%0d busy_o=%b", n, state_o, busy_o);
    while (q.size() > 0 && q[0].cyc <= n) begin
      me    = q.pop_front();
      total = total + 1;
      act   = {state_o, clk_gating_dc_fifo_o, reset_type1_efpga_o, enable_efpga_o,
               busy_o, seq_done_o, error_o};
      if (me.cyc == n && act == me.v) pass = pass + 1;
      else $display("FAIL %s cyc=%0d: got st=%0d ck=%b rst=%h en=%h b/d/e=%b%b%b, want st=%0d ck=%b rst=%h en=%h b/d/e=%b%b%b",
                    me.nm, me.cyc, act[17:15], act[14], act[13:10], act[9:3], act[2], act[1], act[0],
                    me.v[17:15], me.v[14], me.v[13:10], me.v[9:3], me.v[2], me.v[1], me.v[0]);
    end
  end

  initial begin
    int t0;
    repeat (2) @(negedge HCLK);
    ex(n+1, "reset_state", 3'd0, 1'b0, 4'hF, 7'h00, 1'b0, 1'b0, 1'b0);
    @(negedge HCLK);
    HRESET = 1'b0;
    ex(n+1, "idle_after_reset", 3'd0, 1'b0, 4'hF, 7'h00, 1'b0, 1'b0, 1'b0);

    @(negedge HCLK);
    cfg_done_i = 1'b1;
    t0 = n;
    ex(t0+1,  "s1_ungate",       3'd1, 1'b1, 4'hF, 7'h00, 1'b1, 1'b0, 1'b0);
    ex(t0+4,  "s1_ungate_hold",  3'd1, 1'b1, 4'hF, 7'h00, 1'b1, 1'b0, 1'b0);
    ex(t0+5,  "s1_rst_E",        3'd2, 1'b1, 4'hE, 7'h00, 1'b1, 1'b0, 1'b0);
    ex(t0+9,  "s1_rst_C",        3'd2, 1'b1, 4'hC, 7'h00, 1'b1, 1'b0, 1'b0);
    ex(t0+13, "s1_rst_8",        3'd2, 1'b1, 4'h8, 7'h00, 1'b1, 1'b0, 1'b0);
    ex(t0+17, "s1_wait_done",    3'd3, 1'b1, 4'h0, 7'h00, 1'b1, 1'b0, 1'b0);
    ex(t0+18, "s1_run_done",     3'd4, 1'b1, 4'h0, 7'h7F, 1'b0, 1'b1, 1'b0);
    ex(t0+19, "s1_done_pulse",   3'd4, 1'b1, 4'h0, 7'h7F, 1'b0, 1'b0, 1'b0);
    ex(t0+26, "s1_start_in_run", 3'd4, 1'b1, 4'h0, 7'h7F, 1'b0, 1'b0, 1'b0);
    ex(t0+31, "s1_stop_en0",     3'd5, 1'b1, 4'h0, 7'h00, 1'b1, 1'b0, 1'b0);
    ex(t0+34, "s1_shut_hold",    3'd5, 1'b1, 4'h0, 7'h00, 1'b1, 1'b0, 1'b0);
    ex(t0+35, "s1_shut_rstF",    3'd5, 1'b1, 4'hF, 7'h00, 1'b1, 1'b0, 1'b0);
    ex(t0+38, "s1_shut_hold2",   3'd5, 1'b1, 4'hF, 7'h00, 1'b1, 1'b0, 1'b0);
    ex(t0+39, "s1_idle_gated",   3'd0, 1'b0, 4'hF, 7'h00, 1'b0, 1'b0, 1'b0);
    for (int r = 0; r <= 41; r++) begin
      if (r > 0) @(negedge HCLK);
      start_i = (r == 0 || r == 25);
      stop_i  = (r == 30);
    end

    @(negedge HCLK);
    cfg_done_i = 1'b0;
    t0 = n;
    ex(t0+17, "s2_wait_done",    3'd3, 1'b1, 4'h0, 7'h00, 1'b1, 1'b0, 1'b0);
    ex(t0+48, "s2_wait_last",    3'd3, 1'b1, 4'h0, 7'h00, 1'b1, 1'b0, 1'b0);
    ex(t0+49, "s2_timeout",      3'd6, 1'b0, 4'hF, 7'h00, 1'b0, 1'b0, 1'b1);
    ex(t0+53, "s2_stop_in_err",  3'd6, 1'b0, 4'hF, 7'h00, 1'b0, 1'b0, 1'b1);
    ex(t0+56, "s2_retry",        3'd1, 1'b1, 4'hF, 7'h00, 1'b1, 1'b0, 1'b0);
    ex(t0+60, "s2_retry_rst_E",  3'd2, 1'b1, 4'hE, 7'h00, 1'b1, 1'b0, 1'b0);
    ex(t0+72, "s2_retry_wait",   3'd3, 1'b1, 4'h0, 7'h00, 1'b1, 1'b0, 1'b0);
    ex(t0+73, "s2_retry_run",    3'd4, 1'b1, 4'h0, 7'h7F, 1'b0, 1'b1, 1'b0);
    ex(t0+80, "s2_run_hold",     3'd4, 1'b1, 4'h0, 7'h7F, 1'b0, 1'b0, 1'b0);
    ex(t0+81, "s2_cfg_drop",     3'd6, 1'b0, 4'hF, 7'h00, 1'b0, 1'b0, 1'b1);
    for (int r = 0; r <= 82; r++) begin
      if (r > 0) @(negedge HCLK);
      start_i    = (r == 0 || r == 55);
      stop_i     = (r == 52);
      cfg_done_i = (r >= 56 && r < 80);
    end

    @(negedge HCLK);
    HRESET = 1'b1;
    ex(n+1, "s2_reset_from_err", 3'd0, 1'b0, 4'hF, 7'h00, 1'b0, 1'b0, 1'b0);
    @(negedge HCLK);
    HRESET = 1'b0;

    @(negedge HCLK);
    t0 = n;
    ex(t0+1,  "s3_both_idle",    3'd0, 1'b0, 4'hF, 7'h00, 1'b0, 1'b0, 1'b0);
    ex(t0+2,  "s3_both_idle2",   3'd0, 1'b0, 4'hF, 7'h00, 1'b0, 1'b0, 1'b0);
    ex(t0+4,  "s3_ungate",       3'd1, 1'b1, 4'hF, 7'h00, 1'b1, 1'b0, 1'b0);
    ex(t0+8,  "s3_rst_E",        3'd2, 1'b1, 4'hE, 7'h00, 1'b1, 1'b0, 1'b0);
    ex(t0+11, "s3_both_rstrel",  3'd5, 1'b1, 4'hE, 7'h00, 1'b1, 1'b0, 1'b0);
    ex(t0+15, "s3_shut_rstF",    3'd5, 1'b1, 4'hF, 7'h00, 1'b1, 1'b0, 1'b0);
    ex(t0+19, "s3_idle",         3'd0, 1'b0, 4'hF, 7'h00, 1'b0, 1'b0, 1'b0);
    ex(t0+23, "s3_ungate2",      3'd1, 1'b1, 4'hF, 7'h00, 1'b1, 1'b0, 1'b0);
    ex(t0+31, "s3_rst_C",        3'd2, 1'b1, 4'hC, 7'h00, 1'b1, 1'b0, 1'b0);
    ex(t0+32, "s3_rst_C_hold",   3'd2, 1'b1, 4'hC, 7'h00, 1'b1, 1'b0, 1'b0);
    ex(t0+33, "s3_hreset",       3'd0, 1'b0, 4'hF, 7'h00, 1'b0, 1'b0, 1'b0);
    ex(t0+35, "s3_idle_after",   3'd0, 1'b0, 4'hF, 7'h00, 1'b0, 1'b0, 1'b0);
    for (int r = 0; r <= 35; r++) begin
      if (r > 0) @(negedge HCLK);
      start_i = (r == 0 || r == 3 || r == 10 || r == 22);
      stop_i  = (r == 0 || r == 10);
      HRESET  = (r == 32);
    end

    for (int w = 0; w < 100 && q.size() > 0; w++) @(negedge HCLK);
    while (q.size() > 0) begin
      me    = q.pop_front();
      total = total + 1;
      $display("FAIL %s cyc=%0d: never checked", me.nm, me.cyc);
    end
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
